subbytes_shiftrows_serial: RTL and testbench
============================================

Name: subbytes_shiftrows_serial

Overview:
- Area-optimised SubBytes+ShiftRows round stage; also performs the inverse pair for decryption.
- Sits directly upstream of the MixColumns stage in the round datapath, and its state_out feeds MixColumns' state_in.
- Uses BYTES_PER_CYCLE shared S-box datapaths, iterated over the 16 state bytes, instead of 16 parallel S-boxes.
- Uses the same ena/done pulse convention and the same 128-bit state byte layout as the rest of the round datapath.

Parameters:
- BYTES_PER_CYCLE, 1: S-box lanes; legal values 1, 2, 4, 8, 16; latency is 16/BYTES_PER_CYCLE processing cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- ena  input  1  start pulse; sampled only when busy=0.
- inv  input  1  0 = SubBytes then ShiftRows; 1 = InvShiftRows then InvSubBytes. Latched with ena.
- state_in  input  128  input state; latched on the accepted ena edge.
- state_out  output  128  result register; holds its value until the next completion.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when state_out is updated.

Behaviour:
- Byte layout: byte k = state_in[8k+7:8k], with k = 4*c + r (column c, row r). Byte 0 = row 0, column 0, at the LSB; each 32-bit column holds row 0 in its low byte.
- Forward mode: out byte (4c+r) = SBOX(in byte (4*((c+r) mod 4) + r)).
- Inverse mode: out byte (4c+r) = INV_SBOX(in byte (4*((c-r) mod 4) + r)), with mod giving 0..3.
- S-box: implemented internally, either as GF(2^8) inversion (polynomial 0x11B) plus affine transform, or as a 256-entry table. It must be FIPS-197 exact, e.g. SBOX(00)=63, SBOX(53)=ED, INV_SBOX(63)=00.
- Reset values: state_out=0, busy=0, done=0. The internal input register, inv latch, byte counter and partial result all clear to 0.
- States:
  - IDLE: busy=0. If ena=1, latch state_in and inv, clear counter, go to RUN. If ena=0, stay in IDLE.
  - RUN: busy=1. Each cycle, compute BYTES_PER_CYCLE output bytes at indices counter..counter+N-1 into the partial register, then counter += N.
  - RUN exit: when the last group is written (counter == 16-N), go to DONE.
  - DONE: transfer the full result into state_out, pulse done=1 for exactly one cycle, set busy=0, return to IDLE.
- Latency: with the accept edge as edge 0, processing occupies edges 1..16/N. state_out and done update at edge 16/N+1; for N=1, done is high after edge 17.
- ena while busy=1 (RUN or DONE): ignored; no restart, no relatch.
- ena in the cycle after done (back-to-back): accepted normally; throughput is one block per 16/N+2 cycles.
- state_in and inv changing during RUN: no effect on the result, because they were latched at accept.
- done is never asserted without a state_out update. state_out never changes except at completion or on reset.
- rst asserted mid-operation: immediately returns to IDLE, partial result discarded, busy and done low, state_out=0. The first ena after rst deasserts starts a fresh operation.
- Counter is 5 bits and must not wrap past 16; no out-of-range byte index is ever addressed.

Test Plan:
- FIPS-197 App. B round 1, N=1, inv=0: state_in=128'h0848f8e92a8dc69a2be2f4a0bee33d19 -> after 17 edges, done=1 for one cycle and state_out=128'he598271ef11141b8ae52b4e0305dbfd4.
- Same output vector with inv=1 -> state_out=128'h0848f8e92a8dc69a2be2f4a0bee33d19. Repeat for N=2, 4, 8, 16 and check latency 16/N+1.
- state_in=0, inv=0 -> all bytes 0x63. state_in all bytes 0x63, inv=1 -> state_out=0.
- Pulse ena again 3 cycles after accept with different state_in -> ignored: single done, result from the first input, busy high throughout.
- Assert rst on edge 8 of RUN -> busy=0, done=0, state_out=0 immediately. A new ena then gives the correct result with full latency.
- Back-to-back: ena in the cycle after done with a new vector -> accepted; second done exactly 18 cycles after the first (N=1).

Source files
------------

// File: rtl/subbytes_shiftrows_serial_if.sv
// Handshake/bus bundle for the serial SubBytes+ShiftRows stage.
//   ena       : start pulse, sampled only while busy is low
//   inv       : 0 = SubBytes then ShiftRows, 1 = InvShiftRows then InvSubBytes
//   state_in  : 128-bit input state, byte k = [8k+7:8k], k = 4*col + row
//   state_out : 128-bit result register
//   busy      : operation in progress
//   done      : one-cycle pulse when state_out is updated
interface subbytes_shiftrows_serial_if;
    localparam int unsigned STATE_W = 128;

    logic               ena;
    logic               inv;
    logic [STATE_W-1:0] state_in;
    logic [STATE_W-1:0] state_out;
    logic               busy;
    logic               done;

    modport master (
        output ena, inv, state_in,
        input  state_out, busy, done
    );

    modport slave (
        input  ena, inv, state_in,
        output state_out, busy, done
    );
endinterface

// File: rtl/subbytes_shiftrows_serial.sv
// Area-optimised SubBytes+ShiftRows (and inverse) round stage.
// BYTES_PER_CYCLE shared S-box lanes iterate over the 16 state bytes;
// the result is published in state_out with a one-cycle done pulse
// 16/BYTES_PER_CYCLE+1 edges after the accepting edge.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : slave side of subbytes_shiftrows_serial_if (ena/inv/state_in in,
//         state_out/busy/done out, all outputs registered)
module subbytes_shiftrows_serial #(
    parameter int unsigned BYTES_PER_CYCLE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    subbytes_shiftrows_serial_if.slave    bus
);

    localparam int unsigned STATE_W   = 128;
    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned LAST_CNT  = NUM_BYTES - BYTES_PER_CYCLE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] aa;
        logic [7:0] p;
        aa = a;
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    state_e               state_q, state_d;
    logic [STATE_W-1:0]   in_q, in_d;
    logic                 inv_q, inv_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STATE_W-1:0]   part_q, part_d;
    logic [STATE_W-1:0]   out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [7:0]           lane_byte [BYTES_PER_CYCLE];
    logic [IDX_W-1:0]     lane_idx  [BYTES_PER_CYCLE];

    // S-box lanes: one shared inversion per lane, affine on the side the mode needs
    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        logic [IDX_W-1:0] k;
        logic [1:0]       row;
        logic [1:0]       col;
        logic [1:0]       src_col;
        logic [7:0]       src_byte;
        logic [7:0]       pre;
        logic [7:0]       inv_out;

        // counter is always a multiple of the lane count, so this never overflows
        assign k        = cnt_q[IDX_W-1:0] + IDX_W'(l);
        assign row      = k[1:0];
        assign col      = k[3:2];
        // 2-bit arithmetic gives the mod-4 column rotation for free
        assign src_col  = inv_q ? (col - row) : (col + row);
        assign src_byte = in_q[8*{src_col, row} +: 8];
        assign pre      = inv_q ? inv_affine(src_byte) : src_byte;
        assign inv_out  = gf_inv(pre);

        assign lane_byte[l] = inv_q ? inv_out : affine(inv_out);
        assign lane_idx[l]  = k;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        inv_d   = inv_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ena) begin
                    in_d    = bus.state_in;
                    inv_d   = bus.inv;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
                    part_d[8*lane_idx[l] +: 8] = lane_byte[l];
                end
                cnt_d = cnt_q + CNT_W'(BYTES_PER_CYCLE);
                if (cnt_q == CNT_W'(LAST_CNT)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_d   = part_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            in_q    <= '0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            inv_q   <= inv_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.state_out = out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_subbytes_shiftrows_serial.sv
// Self-checking bench for subbytes_shiftrows_serial: one instance per legal
// lane count (1,2,4,8,16) driven in parallel, compared against a table-based
// reference model of the FIPS-197 SubBytes/ShiftRows rules.
module tb_subbytes_shiftrows_serial;

    localparam int NDUT = 5;
    localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [127:0] FIPS_OUT = 128'he598271ef11141b8ae52b4e0305dbfd4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b0;
    logic         inv = 1'b0;
    logic [127:0] state_in = '0;

    logic [127:0] out_a  [NDUT];
    logic         busy_a [NDUT];
    logic         done_a [NDUT];

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        subbytes_shiftrows_serial_if ifc ();
        assign ifc.ena      = ena;
        assign ifc.inv      = inv;
        assign ifc.state_in = state_in;
        assign out_a[gi]    = ifc.state_out;
        assign busy_a[gi]   = ifc.busy;
        assign done_a[gi]   = ifc.done;

        subbytes_shiftrows_serial #(.BYTES_PER_CYCLE(1 << gi)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );
    end

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_tab [256];
    logic [7:0] isbox_tab[256];

    int first_done[NDUT];
    int done_cnt  [NDUT];
    int busy_bad  [NDUT];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // Build S-box by walking the multiplicative group with generator 3 and its inverse
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        for (int it = 0; it < 255; it++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
            sbox_tab[p] = x ^ 8'h63;
        end
        sbox_tab[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox_tab[sbox_tab[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic iv);
        logic [127:0] res;
        logic [7:0]   b;
        int c, r, src;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            c   = k / 4;
            r   = k % 4;
            src = iv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
            b   = d[8*src +: 8];
            res[8*k +: 8] = iv ? isbox_tab[b] : sbox_tab[b];
        end
        return res;
    endfunction

    // Accepting edge is edge 0
    task automatic start(input logic [127:0] d, input logic iv);
        state_in = d;
        inv      = iv;
        ena      = 1'b1;
        @(posedge clk);
        #1;
        ena = 1'b0;
    endtask

    // Watch edges 1..n_edges; optionally re-pulse ena (with other data/inv) before pulse_edge
    task automatic observe(input int n_edges, input int pulse_edge, input logic [127:0] pulse_data);
        for (int i = 0; i < NDUT; i++) begin
            first_done[i] = 0;
            done_cnt[i]   = 0;
            busy_bad[i]   = 0;
        end
        for (int e = 1; e <= n_edges; e++) begin
            if (e == pulse_edge) begin
                ena      = 1'b1;
                state_in = pulse_data;
                inv      = ~inv;
            end
            @(posedge clk);
            #1;
            ena = 1'b0;
            for (int i = 0; i < NDUT; i++) begin
                if (done_a[i]) begin
                    done_cnt[i]++;
                    if (first_done[i] == 0) first_done[i] = e;
                end
                if (first_done[i] == 0 && !busy_a[i]) busy_bad[i] = 1;
                if (first_done[i] == e && busy_a[i]) busy_bad[i] = 1;
            end
        end
    endtask

    task automatic check_dut(input string tag, input int i, input logic [127:0] exp);
        check_eq($sformatf("%s_n%0d_latency", tag, 1 << i), 128'(first_done[i]), 128'(16 / (1 << i) + 1));
        check_eq($sformatf("%s_n%0d_done_count", tag, 1 << i), 128'(done_cnt[i]), 128'(1));
        check_eq($sformatf("%s_n%0d_busy", tag, 1 << i), 128'(busy_bad[i]), 128'(0));
        check_eq($sformatf("%s_n%0d_out", tag, 1 << i), out_a[i], exp);
    endtask

    task automatic run_all(input string tag, input logic [127:0] d, input logic iv, input logic [127:0] exp);
        start(d, iv);
        observe(40, 0, '0);
        for (int i = 0; i < NDUT; i++) check_dut(tag, i, exp);
    endtask

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] d;
        logic         iv;
        int           t1;
        int           t2;

        build_tables();

        // Reset values
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("reset_n%0d_out", 1 << i), out_a[i], '0);
            check_eq($sformatf("reset_n%0d_busy", 1 << i), 128'(busy_a[i]), '0);
            check_eq($sformatf("reset_n%0d_done", 1 << i), 128'(done_a[i]), '0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        check_eq("model_fips_fwd", model(FIPS_IN, 1'b0), FIPS_OUT);

        // Known-answer vectors
        run_all("fips_fwd", FIPS_IN, 1'b0, FIPS_OUT);
        run_all("fips_inv", FIPS_OUT, 1'b1, FIPS_IN);
        run_all("zero_fwd", '0, 1'b0, {16{8'h63}});
        run_all("x63_inv", {16{8'h63}}, 1'b1, '0);

        // Random vectors in both modes
        for (int n = 0; n < 8; n++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            iv = 1'($urandom_range(0, 1));
            run_all($sformatf("rand%0d", n), d, iv, model(d, iv));
        end

        // ena pulsed 3 edges after accept with new data and flipped inv: ignored while busy
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        start(a, 1'b0);
        observe(40, 3, b);
        for (int i = 0; i < 3; i++) check_dut("ena_ignored", i, model(a, 1'b0));

        // Reset in the middle of RUN
        a = {$urandom, $urandom, $urandom, $urandom};
        start(a, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 128'(busy_a[0]), '0);
        check_eq("midrst_done", 128'(done_a[0]), '0);
        for (int i = 0; i < NDUT; i++) check_eq($sformatf("midrst_n%0d_out", 1 << i), out_a[i], '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        run_all("post_rst", d, 1'b1, model(d, 1'b1));

        // Back-to-back on the single-lane instance
        a  = {$urandom, $urandom, $urandom, $urandom};
        b  = {$urandom, $urandom, $urandom, $urandom};
        t1 = 0;
        t2 = 0;
        start(a, 1'b0);
        for (int e = 1; e <= 60; e++) begin
            if (t1 != 0 && e == t1 + 1) begin
                ena      = 1'b1;
                state_in = b;
                inv      = 1'b1;
            end
            @(posedge clk);
            #1;
            ena = 1'b0;
            if (done_a[0]) begin
                if (t1 == 0) begin
                    t1 = e;
                    check_eq("b2b_first_out", out_a[0], model(a, 1'b0));
                end else if (t2 == 0) begin
                    t2 = e;
                end
            end
        end
        check_eq("b2b_first_latency", 128'(t1), 128'(17));
        check_eq("b2b_spacing", 128'(t2 - t1), 128'(18));
        check_eq("b2b_second_out", out_a[0], model(b, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
